// File: rtl/bwt_pkg.sv
// Definitions shared by the forward BWT encoder and the inverse BWT decoder.
package bwt_pkg;

    localparam int         BWT_STRING_LEN  = 32;
    localparam int         BWT_ELEMENT_LEN = 8;
    localparam logic [7:0] SENTINEL        = 8'h24;

    typedef enum logic [2:0] {
        IDLE,
        BUILD_LF,
        WALK,
        DONE,
        WAIT_RELEASE
    } bwt_state_t;

endpackage

// File: rtl/ibwt_lf_unit.sv
// Combinational LF-mapping for one row: rank of L[idx] among all symbols of L,
// where the sentinel sorts below every other symbol.
module ibwt_lf_unit
    import bwt_pkg::*;
#(
    parameter  int STRING_LEN  = BWT_STRING_LEN,
    parameter  int ELEMENT_LEN = BWT_ELEMENT_LEN,
    localparam int IDX_W       = $clog2(STRING_LEN)
) (
    input  logic [ELEMENT_LEN-1:0] l_array [STRING_LEN],
    input  logic [IDX_W-1:0]       idx,
    output logic [IDX_W-1:0]       lf_value,
    output logic                   is_sentinel
);

    localparam logic [ELEMENT_LEN-1:0] SENT = ELEMENT_LEN'(SENTINEL);

    function automatic logic sym_less(input logic [ELEMENT_LEN-1:0] a,
                                      input logic [ELEMENT_LEN-1:0] b);
        if (b == SENT) return 1'b0;
        if (a == SENT) return 1'b1;
        return a < b;
    endfunction

    logic [ELEMENT_LEN-1:0] cur;
    logic [IDX_W:0]         less_cnt;
    logic [IDX_W:0]         eq_cnt;

    always_comb begin
        cur      = l_array[idx];
        less_cnt = '0;
        eq_cnt   = '0;
        for (int j = 0; j < STRING_LEN; j++) begin
            if (sym_less(l_array[j], cur))
                less_cnt = less_cnt + 1'b1;
            // Equal symbols earlier in L keep their relative order in F.
            if ((l_array[j] == cur) && (j < int'(idx)))
                eq_cnt = eq_cnt + 1'b1;
        end
        lf_value    = IDX_W'(less_cnt + eq_cnt);
        is_sentinel = (cur == SENT);
    end

endmodule

// File: rtl/ibwt_decoder.sv
// Inverse Burrows-Wheeler transform: builds the LF table one row per cycle,
// then walks it backwards from the sentinel row to rebuild the original string.
module ibwt_decoder
    import bwt_pkg::*;
#(
    parameter  int STRING_LEN  = BWT_STRING_LEN,
    parameter  int ELEMENT_LEN = BWT_ELEMENT_LEN,
    localparam int IDX_W       = $clog2(STRING_LEN),
    localparam int CNT_W       = IDX_W + 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [STRING_LEN*ELEMENT_LEN-1:0] input_string_char,
    output logic [STRING_LEN*ELEMENT_LEN-1:0] output_string_char,
    output logic                              valid_out,
    output logic                              error,
    output logic                              busy
);

    localparam logic [ELEMENT_LEN-1:0] SENT = ELEMENT_LEN'(SENTINEL);

    bwt_state_t state;
    bwt_state_t state_next;

    logic [ELEMENT_LEN-1:0] l_mem  [STRING_LEN];
    logic [IDX_W-1:0]       lf_mem [STRING_LEN];
    logic [ELEMENT_LEN-1:0] s_mem  [STRING_LEN-1];

    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] k;
    logic [IDX_W-1:0] r;
    logic [CNT_W-1:0] sent_cnt;
    logic [CNT_W-1:0] sent_cnt_next;
    logic             err_flag;

    logic [IDX_W-1:0]                  lf_value;
    logic                              lf_is_sentinel;
    logic                              last_idx;
    logic [STRING_LEN*ELEMENT_LEN-1:0] s_packed;

    ibwt_lf_unit #(
        .STRING_LEN  (STRING_LEN),
        .ELEMENT_LEN (ELEMENT_LEN)
    ) u_lf (
        .l_array     (l_mem),
        .idx         (idx),
        .lf_value    (lf_value),
        .is_sentinel (lf_is_sentinel)
    );

    assign last_idx      = (idx == IDX_W'(STRING_LEN - 1));
    assign sent_cnt_next = sent_cnt + CNT_W'(lf_is_sentinel);
    assign busy          = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:         if (start) state_next = BUILD_LF;
            BUILD_LF:     if (last_idx)
                              state_next = (sent_cnt_next == CNT_W'(1)) ? WALK : DONE;
            WALK:         if (k == '0) state_next = DONE;
            DONE:         state_next = WAIT_RELEASE;
            WAIT_RELEASE: if (!start) state_next = IDLE;
            default:      state_next = IDLE;
        endcase
    end

    // The last symbol of the original string is always the sentinel, so it is never stored.
    always_comb begin
        s_packed = '0;
        for (int i = 0; i < STRING_LEN - 1; i++)
            s_packed[i*ELEMENT_LEN +: ELEMENT_LEN] = s_mem[i];
        s_packed[(STRING_LEN-1)*ELEMENT_LEN +: ELEMENT_LEN] = SENT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            idx                <= '0;
            k                  <= '0;
            r                  <= '0;
            sent_cnt           <= '0;
            err_flag           <= 1'b0;
            valid_out          <= 1'b0;
            error              <= 1'b0;
            output_string_char <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx       <= '0;
                        sent_cnt  <= '0;
                        valid_out <= 1'b0;
                        error     <= 1'b0;
                    end
                end
                BUILD_LF: begin
                    sent_cnt <= sent_cnt_next;
                    idx      <= idx + 1'b1;
                    if (last_idx) begin
                        r        <= '0;
                        k        <= IDX_W'(STRING_LEN - 2);
                        err_flag <= (sent_cnt_next != CNT_W'(1));
                    end
                end
                WALK: begin
                    r <= lf_mem[r];
                    k <= k - 1'b1;
                end
                DONE: begin
                    output_string_char <= err_flag ? '0 : s_packed;
                    valid_out          <= 1'b1;
                    error              <= err_flag;
                end
                WAIT_RELEASE: begin
                    if (!start) begin
                        valid_out <= 1'b0;
                        error     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage arrays carry no reset; they are always rewritten before being read.
    always_ff @(posedge clk) begin
        if (!rst && (state == IDLE) && start) begin
            for (int i = 0; i < STRING_LEN; i++)
                l_mem[i] <= input_string_char[i*ELEMENT_LEN +: ELEMENT_LEN];
        end
        if (state == BUILD_LF)
            lf_mem[idx] <= lf_value;
        if (state == WALK)
            s_mem[k] <= l_mem[r];
    end

endmodule
